regfile_write_arbiter: RTL

//  Owns the single write port of the 64x64 register file and shares it between two

---
 rtl/regfile_write_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Write-port owner for the 64x64 register file: round-robin arbitration between
// the ALU writeback (req0) and the load/debug unit (req1), plus a clear sweep.
module regfile_write_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid0,
  input  logic [ADDR_W-1:0] adr0,
  input  logic [DATA_W-1:0] data0,
  output logic              ready0,
  input  logic              valid1,
  input  logic [ADDR_W-1:0] adr1,
  input  logic [DATA_W-1:0] data1,
  output logic              ready1,
  input  logic              clearStart,
  output logic [ADDR_W-1:0] writeAdr,
  output logic [DATA_W-1:0] writeData,
  output logic              writeEnable,
  output logic [1:0]        writeSrc,
  output logic              busy,
  output logic              clearDone
);

  typedef enum logic {IDLE, CLEAR} stateT;

  localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(NUM_REGS - 1);
  localparam logic [1:0]        SRC_REQ0  = 2'd0;
  localparam logic [1:0]        SRC_REQ1  = 2'd1;
  localparam logic [1:0]        SRC_CLEAR = 2'd2;

  stateT             state;
  stateT             nextState;
  logic              prio;
  logic [ADDR_W-1:0] clearCount;
  logic              grant0;
  logic              grant1;
  logic              startSweep;
  logic              lastClear;

  assign lastClear = (clearCount == LAST_REG);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (clearStart) nextState = CLEAR;
      CLEAR:   if (lastClear)  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // A pending clear request locks out both writers for the cycle it arrives in.
  always_comb begin
    ready0     = 1'b0;
    ready1     = 1'b0;
    startSweep = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        startSweep = clearStart && !reset;
        ready0     = !reset && !clearStart && (!valid1 || !prio);
        ready1     = !reset && !clearStart && (!valid0 || prio);
      end
      CLEAR: begin
        busy = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
    grant0 = valid0 && ready0;
    grant1 = valid1 && ready1;
  end

  // clearCount always equals the address currently shown on writeAdr during a sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      writeAdr    <= '0;
      writeData   <= '0;
      writeEnable <= 1'b0;
      writeSrc    <= SRC_REQ0;
      clearDone   <= 1'b0;
      clearCount  <= '0;
      prio        <= 1'b0;
    end else begin
      writeEnable <= 1'b0;
      clearDone   <= 1'b0;
      if (state == CLEAR) begin
        if (lastClear) begin
          clearCount <= '0;
          clearDone  <= 1'b1;
        end else begin
          clearCount  <= clearCount + 1'b1;
          writeEnable <= 1'b1;
          writeAdr    <= clearCount + 1'b1;
          writeData   <= '0;
          writeSrc    <= SRC_CLEAR;
        end
      end else if (startSweep) begin
        clearCount  <= '0;
        writeEnable <= 1'b1;
        writeAdr    <= '0;
        writeData   <= '0;
        writeSrc    <= SRC_CLEAR;
      end else if (grant0) begin
        writeEnable <= 1'b1;
        writeAdr    <= adr0;
        writeData   <= data0;
        writeSrc    <= SRC_REQ0;
        prio        <= 1'b1;
      end else if (grant1) begin
        writeEnable <= 1'b1;
        writeAdr    <= adr1;
        writeData   <= data1;
        writeSrc    <= SRC_REQ1;
        prio        <= 1'b0;
      end
    end
  end

endmodule
